// File: rtl/sid_envelope_multi.sv
// Multi-voice SID ADSR envelope generator: NUM_VOICES independent envelopes with clock enable,
// cycle-count rate table, optional exponential decay curve and per-voice state readback.
module sid_envelope_multi #(
    parameter int unsigned NUM_VOICES = 3,
    parameter bit          EXP_DECAY  = 1'b1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clk_en,
    input  logic [NUM_VOICES-1:0]   gate,
    input  logic [8*NUM_VOICES-1:0] att_dec,
    input  logic [8*NUM_VOICES-1:0] sus_rel,
    output logic [8*NUM_VOICES-1:0] envelope,
    output logic [2*NUM_VOICES-1:0] env_state
);

    typedef enum logic [1:0] {
        StAttack       = 2'b00,
        StDecaySustain = 2'b01,
        StRelease      = 2'b10
    } env_state_e;

    function automatic logic [14:0] rate_period(input logic [3:0] nib);
        logic [14:0] p;
        case (nib)
            4'h0:    p = 15'd9;
            4'h1:    p = 15'd32;
            4'h2:    p = 15'd63;
            4'h3:    p = 15'd95;
            4'h4:    p = 15'd149;
            4'h5:    p = 15'd220;
            4'h6:    p = 15'd267;
            4'h7:    p = 15'd313;
            4'h8:    p = 15'd391;
            4'h9:    p = 15'd977;
            4'hA:    p = 15'd1954;
            4'hB:    p = 15'd3126;
            4'hC:    p = 15'd3907;
            4'hD:    p = 15'd11720;
            4'hE:    p = 15'd19532;
            default: p = 15'd31251;
        endcase
        return p;
    endfunction

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        env_state_e  state_q, state_d;
        logic [7:0]  env_q, env_d;
        logic        gate_prev_q;
        logic [14:0] rate_cnt_q, rate_cnt_d;
        logic [4:0]  exp_cnt_q, exp_cnt_d;
        logic [4:0]  exp_period_q, exp_period_d;
        logic        hold_zero_q, hold_zero_d;
        logic [7:0]  ad, sr;
        logic [3:0]  rate_sel;
        logic [14:0] period;
        logic        rate_hit;
        logic        step;

        assign ad = att_dec[8*v +: 8];
        assign sr = sus_rel[8*v +: 8];

        always_comb begin
            rate_sel = sr[3:0];
            case (state_q)
                StAttack:       rate_sel = ad[7:4];
                StDecaySustain: rate_sel = ad[3:0];
                default:        rate_sel = sr[3:0];
            endcase
        end

        assign period   = rate_period(rate_sel);
        assign rate_hit = (rate_cnt_q == period - 15'd1);

        always_comb begin
            rate_cnt_d   = rate_cnt_q + 15'd1;
            exp_cnt_d    = exp_cnt_q;
            exp_period_d = exp_period_q;
            hold_zero_d  = hold_zero_q;
            env_d        = env_q;
            state_d      = state_q;
            step         = 1'b0;

            // No clear on state change: a shrunken period must wait for the wrap (SID delay bug).
            if (rate_hit) begin
                rate_cnt_d = '0;
                if (state_q == StAttack || exp_cnt_q + 5'd1 == exp_period_q) begin
                    step      = !hold_zero_q;
                    exp_cnt_d = '0;
                end else begin
                    exp_cnt_d = exp_cnt_q + 5'd1;
                end
            end

            if (step) begin
                case (state_q)
                    StAttack: begin
                        if (env_q != 8'hFF) env_d = env_q + 8'd1;
                        if (env_q >= 8'hFE) state_d = StDecaySustain;
                    end
                    StDecaySustain: begin
                        if (env_q > {sr[7:4], sr[7:4]}) env_d = env_q - 8'd1;
                    end
                    default: begin
                        if (env_q != 8'h00) env_d = env_q - 8'd1;
                    end
                endcase

                case (env_d)
                    8'hFF: exp_period_d = 5'd1;
                    8'h5D: exp_period_d = 5'd2;
                    8'h36: exp_period_d = 5'd4;
                    8'h1A: exp_period_d = 5'd8;
                    8'h0E: exp_period_d = 5'd16;
                    8'h06: exp_period_d = 5'd30;
                    8'h00: begin
                        exp_period_d = 5'd1;
                        hold_zero_d  = 1'b1;
                    end
                    default: ;
                endcase
                if (!EXP_DECAY) exp_period_d = 5'd1;
            end

            // Gate edges override any step-driven state change on the same tick.
            if (gate[v] && !gate_prev_q) begin
                state_d     = StAttack;
                hold_zero_d = 1'b0;
            end else if (!gate[v] && gate_prev_q) begin
                state_d = StRelease;
            end
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                state_q      <= StRelease;
                env_q        <= 8'h00;
                gate_prev_q  <= 1'b0;
                rate_cnt_q   <= '0;
                exp_cnt_q    <= '0;
                exp_period_q <= 5'd1;
                hold_zero_q  <= 1'b1;
            end else if (clk_en) begin
                state_q      <= state_d;
                env_q        <= env_d;
                gate_prev_q  <= gate[v];
                rate_cnt_q   <= rate_cnt_d;
                exp_cnt_q    <= exp_cnt_d;
                exp_period_q <= exp_period_d;
                hold_zero_q  <= hold_zero_d;
            end
        end

        assign envelope[8*v +: 8]  = env_q;
        assign env_state[2*v +: 2] = state_q;
    end

endmodule

// File: tb/tb_sid_envelope_multi.sv
// Directed bench for sid_envelope_multi: a 3-voice exponential instance and a 1-voice linear one.
module tb_sid_envelope_multi;

    logic        clock = 1'b0;
    logic        reset;
    logic        clk_en;
    logic [2:0]  gate;
    logic [23:0] att_dec;
    logic [23:0] sus_rel;
    logic [23:0] envelope;
    logic [5:0]  env_state;

    logic        gate_l;
    logic [7:0]  att_dec_l;
    logic [7:0]  sus_rel_l;
    logic [7:0]  envelope_l;
    logic [1:0]  env_state_l;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    sid_envelope_multi #(
        .NUM_VOICES (3),
        .EXP_DECAY  (1'b1)
    ) u_dut (
        .clock     (clock),
        .reset     (reset),
        .clk_en    (clk_en),
        .gate      (gate),
        .att_dec   (att_dec),
        .sus_rel   (sus_rel),
        .envelope  (envelope),
        .env_state (env_state)
    );

    sid_envelope_multi #(
        .NUM_VOICES (1),
        .EXP_DECAY  (1'b0)
    ) u_dut_lin (
        .clock     (clock),
        .reset     (reset),
        .clk_en    (clk_en),
        .gate      (gate_l),
        .att_dec   (att_dec_l),
        .sus_rel   (sus_rel_l),
        .envelope  (envelope_l),
        .env_state (env_state_l)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance n clock edges; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        clk_en    = 1'b1;
        gate      = 3'b000;
        att_dec   = 24'h000000;
        sus_rel   = 24'h000080;
        gate_l    = 1'b0;
        att_dec_l = 8'h00;
        sus_rel_l = 8'h00;
        tick(2);
        check("rst_env", envelope, 24'h000000);
        check("rst_state", env_state, 6'b101010);
        check("rst_env_lin", envelope_l, 8'h00);
        check("rst_state_lin", env_state_l, 2'b10);
        reset = 1'b0;

        // Attack / decay / sustain on voice 0; gate rises on the 9th tick (a rate hit).
        tick(8);
        gate[0] = 1'b1;
        tick(1);
        check("att_enter_state", env_state[1:0], 2'b00);
        check("att_enter_env", envelope[7:0], 8'h00);
        tick(9);
        check("att_first_step", envelope[7:0], 8'h01);
        tick(2285);
        check("att_fe", envelope[7:0], 8'hFE);
        tick(1);
        check("att_ff", envelope[7:0], 8'hFF);
        check("att_ff_state", env_state[1:0], 2'b01);
        check("idle_voices_env", envelope[23:8], 16'h0000);
        check("idle_voices_state", env_state[5:2], 4'b1010);
        tick(1070);
        check("dec_89", envelope[7:0], 8'h89);
        tick(1);
        check("dec_88", envelope[7:0], 8'h88);
        tick(17);
        check("sus_hold", envelope[7:0], 8'h88);
        check("sus_state", env_state[1:0], 2'b01);

        // Release with exponential curve.
        gate[0] = 1'b0;
        tick(1);
        check("rel_enter_state", env_state[1:0], 2'b10);
        check("rel_enter_env", envelope[7:0], 8'h88);
        tick(386);
        check("rel_5e", envelope[7:0], 8'h5E);
        tick(1);
        check("rel_5d", envelope[7:0], 8'h5D);
        tick(17);
        check("rel_5d_hold", envelope[7:0], 8'h5D);
        tick(1);
        check("rel_5c", envelope[7:0], 8'h5C);
        tick(684);
        check("rel_36", envelope[7:0], 8'h36);
        tick(1008);
        check("rel_1a", envelope[7:0], 8'h1A);
        tick(864);
        check("rel_0e", envelope[7:0], 8'h0E);
        tick(1152);
        check("rel_06", envelope[7:0], 8'h06);
        tick(1619);
        check("rel_01", envelope[7:0], 8'h01);
        tick(1);
        check("rel_00", envelope[7:0], 8'h00);
        tick(2000);
        check("zero_hold", envelope[7:0], 8'h00);
        check("zero_state", env_state[1:0], 2'b10);

        // Delay bug: decay 5 -> 0 with rate_cnt at 100 waits for the 15-bit wrap.
        att_dec = 24'h000005;
        sus_rel = 24'h000000;
        pulse_reset();
        tick(8);
        gate[0] = 1'b1;
        tick(1);
        tick(2295);
        check("bug_att_ff", envelope[7:0], 8'hFF);
        tick(100);
        att_dec = 24'h000000;
        tick(32676);
        check("bug_no_early_step", envelope[7:0], 8'hFF);
        tick(1);
        check("bug_wrap_step", envelope[7:0], 8'hFE);
        tick(9);
        check("bug_next_step", envelope[7:0], 8'hFD);

        // Voice 1 alone; then clk_en freeze and reset mid-attack.
        gate    = 3'b000;
        att_dec = 24'h000000;
        pulse_reset();
        tick(8);
        gate[1] = 1'b1;
        tick(1);
        tick(90);
        check("v1_env", envelope, 24'h000A00);
        check("v1_state", env_state, 6'b100010);
        clk_en = 1'b0;
        tick(1000);
        check("freeze_env", envelope, 24'h000A00);
        check("freeze_state", env_state, 6'b100010);
        clk_en = 1'b1;
        tick(486);
        check("v1_40", envelope[15:8], 8'h40);
        clk_en = 1'b0;
        pulse_reset();
        check("midrst_env", envelope, 24'h000000);
        check("midrst_state", env_state, 6'b101010);
        clk_en = 1'b1;
        tick(1);
        check("restart_state", env_state[3:2], 2'b00);
        tick(7);
        check("restart_env0", envelope[15:8], 8'h00);
        tick(1);
        check("restart_env1", envelope[15:8], 8'h01);

        // Linear instance: full-scale release in 255 steps of 9 ticks.
        gate = 3'b000;
        pulse_reset();
        tick(8);
        gate_l = 1'b1;
        tick(1);
        tick(2294);
        check("lin_att_fe", envelope_l, 8'hFE);
        gate_l = 1'b0;
        tick(1);
        check("lin_att_ff", envelope_l, 8'hFF);
        check("lin_rel_state", env_state_l, 2'b10);
        tick(2286);
        check("lin_01", envelope_l, 8'h01);
        tick(9);
        check("lin_00", envelope_l, 8'h00);
        tick(100);
        check("lin_hold", envelope_l, 8'h00);
        check("lin_other_dut", envelope, 24'h000000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
